// File: rtl/sys_mem_responder.sv
// Wait-state memory responder for the cache controller's system bus.
// Define SYSMEM_PARITY_EN to add per-word even parity with error injection.
module sys_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              SysStrobe,
   input  logic              SysRW,
   input  logic [ADDR_W-1:0] SysAddr,
   input  logic              SysDataOE,
   input  logic [DATA_W-1:0] SysDataIn,
   output logic [DATA_W-1:0] SysDataOut,
   output logic              SysReady,
   output logic              Busy,
`ifdef SYSMEM_PARITY_EN
   input  logic              SysParityFlip,
   output logic              ParityErr,
`endif
   output logic              ProtocolErr
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      XFER
   } state_t;

   localparam logic [3:0] WS_LOAD =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t            state;
   state_t            stateNext;
   logic [3:0]        cnt;
   logic [3:0]        cntNext;
   logic              accept;

   logic              reqRW;
   logic [ADDR_W-1:0] reqAddr;
   logic [DATA_W-1:0] reqData;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic              rdRW;
   logic [ADDR_W-1:0] rdAddr;
   logic              enterRead;
   logic              commit;
   logic              fwd;
   logic [DATA_W-1:0] rdWord;

`ifdef SYSMEM_PARITY_EN
   logic              par [2**ADDR_W];
   logic              reqFlip;
   logic              wrPar;
   logic              rdPar;
`endif

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      accept    = 1'b0;
      unique case (state)
         IDLE: accept = SysStrobe;
         WAIT: begin
            if (cnt == 4'd0) stateNext = XFER;
            else             cntNext   = cnt - 4'd1;
         end
         XFER: begin
            accept    = SysStrobe;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (accept) begin
         stateNext = (WAIT_STATES > 0) ? WAIT : XFER;
         cntNext   = WS_LOAD;
      end
   end

   // A read entering XFER on the same edge a write commits sees the new word.
   assign rdRW      = accept ? SysRW : reqRW;
   assign rdAddr    = accept ? SysAddr : reqAddr;
   assign enterRead = (stateNext == XFER) && rdRW;
   assign commit    = (state == XFER) && !reqRW;
   assign fwd       = commit && (rdAddr == reqAddr);
   assign rdWord    = fwd ? reqData : mem[rdAddr];

`ifdef SYSMEM_PARITY_EN
   assign wrPar = (^reqData) ^ reqFlip;
   assign rdPar = fwd ? wrPar : par[rdAddr];
`endif

   assign SysReady = (state == XFER);
   assign Busy     = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         reqRW       <= 1'b0;
         reqAddr     <= '0;
         reqData     <= '0;
         SysDataOut  <= '0;
         ProtocolErr <= 1'b0;
`ifdef SYSMEM_PARITY_EN
         reqFlip     <= 1'b0;
         ParityErr   <= 1'b0;
`endif
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (accept) begin
            reqRW   <= SysRW;
            reqAddr <= SysAddr;
            reqData <= SysDataIn;
`ifdef SYSMEM_PARITY_EN
            reqFlip <= SysParityFlip;
`endif
         end
         if (enterRead)
            SysDataOut <= rdWord;
         if ((state == WAIT && SysStrobe) ||
             (accept && !SysRW && !SysDataOE))
            ProtocolErr <= 1'b1;
`ifdef SYSMEM_PARITY_EN
         ParityErr <= enterRead && ((^rdWord) != rdPar);
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (commit && !Reset) begin
         mem[reqAddr] <= reqData;
`ifdef SYSMEM_PARITY_EN
         par[reqAddr] <= wrPar;
`endif
      end
   end

endmodule
